// File: rtl/ifetch_pkg.sv
// Shared configuration for the instruction fetch stage: bus widths, PC step,
// fetch FSM encodings and memory-controller read/write constants.
package ifetch_pkg;

    localparam int unsigned AddrBus    = 32;
    localparam int unsigned InstBus    = 32;
    localparam int unsigned IcacheIdxW = 8;
    localparam int unsigned PCStep     = 4;

    localparam logic Read  = 1'b0;
    localparam logic Write = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StIssue = 2'd2,
        StDrain = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational lookup
// and synchronous fill. Only instantiated when ICACHE_EN is defined.
module ifetch_icache #(
    parameter int unsigned IdxW  = 8,
    parameter int unsigned AddrW = 32,
    parameter int unsigned InstW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AddrW-1:0] lookup_addr_i,
    output logic             hit_o,
    output logic [InstW-1:0] rdata_o,
    input  logic             fill_en_i,
    input  logic [AddrW-1:0] fill_addr_i,
    input  logic [InstW-1:0] fill_data_i
);

    localparam int unsigned Lines = 1 << IdxW;
    localparam int unsigned TagW  = AddrW - IdxW - 2;

    logic [Lines-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [InstW-1:0] data_q [Lines];

    logic [IdxW-1:0] lk_idx, fill_idx;
    logic [TagW-1:0] lk_tag, fill_tag;

    assign lk_idx   = lookup_addr_i[IdxW+1:2];
    assign lk_tag   = lookup_addr_i[AddrW-1:IdxW+2];
    assign fill_idx = fill_addr_i[IdxW+1:2];
    assign fill_tag = fill_addr_i[AddrW-1:IdxW+2];

    assign hit_o   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign rdata_o = data_q[lk_idx];

    // Byte offset is always zero for word fetches.
    logic unused_offset;
    assign unused_offset = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: holds the PC, issues one word fetch at a time to the
// memory controller and delivers {pc, inst} to the instruction queue.
// Define ICACHE_EN to add the direct-mapped instruction cache in front of memory.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned ICACHE_IDX_W = IcacheIdxW,
    parameter int unsigned ADDR_W       = AddrBus,
    parameter int unsigned INST_W       = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              mc_req_o,
    output logic [ADDR_W-1:0] mc_addr_o,
    input  logic              mc_done_i,
    input  logic [INST_W-1:0] mc_inst_i,
    input  logic              iq_full_i,
    output logic              iq_valid_o,
    output logic [INST_W-1:0] iq_inst_o,
    output logic [ADDR_W-1:0] iq_pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              mc_req_q, mc_req_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic              iq_valid_q, iq_valid_d;
    logic [INST_W-1:0] iq_inst_q, iq_inst_d;
    logic [ADDR_W-1:0] iq_pc_q, iq_pc_d;

    logic              cache_hit;
    logic [INST_W-1:0] cache_data;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] redirect_target;

    assign pc_next         = pc_q + ADDR_W'(PCStep);
    assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

`ifdef ICACHE_EN
    logic fill_en;

    // Every returned word is filled, including discarded ones: it is correct for its address.
    assign fill_en = rdy && mc_done_i && ((state_q == StWait) || (state_q == StDrain));

    ifetch_icache #(
        .IdxW (ICACHE_IDX_W),
        .AddrW(ADDR_W),
        .InstW(INST_W)
    ) u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_addr_i(pc_q),
        .hit_o        (cache_hit),
        .rdata_o      (cache_data),
        .fill_en_i    (fill_en),
        .fill_addr_i  (mc_addr_q),
        .fill_data_i  (mc_inst_i)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        mc_req_d   = mc_req_q;
        mc_addr_d  = mc_addr_q;
        iq_valid_d = 1'b0;
        iq_inst_d  = iq_inst_q;
        iq_pc_d    = iq_pc_q;

        if (rdy) begin
            if (redirect_i) begin
                pc_d = redirect_target;
                unique case (state_q)
                    // The controller cannot abort: an outstanding fetch must drain first.
                    StWait, StDrain: begin
                        if (mc_done_i) begin
                            mc_req_d = 1'b0;
                            state_d  = StIdle;
                        end else begin
                            state_d  = StDrain;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cache_hit) begin
                            if (!iq_full_i) begin
                                iq_valid_d = 1'b1;
                                iq_inst_d  = cache_data;
                                iq_pc_d    = pc_q;
                                pc_d       = pc_next;
                            end
                        end else begin
                            mc_req_d  = 1'b1;
                            mc_addr_d = pc_q;
                            state_d   = StWait;
                        end
                    end
                    StWait: begin
                        if (mc_done_i) begin
                            hold_d   = mc_inst_i;
                            mc_req_d = 1'b0;
                            state_d  = StIssue;
                        end
                    end
                    StIssue: begin
                        if (!iq_full_i) begin
                            iq_valid_d = 1'b1;
                            iq_inst_d  = hold_q;
                            iq_pc_d    = pc_q;
                            pc_d       = pc_next;
                            state_d    = StIdle;
                        end
                    end
                    StDrain: begin
                        if (mc_done_i) begin
                            mc_req_d = 1'b0;
                            state_d  = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            hold_q     <= '0;
            mc_req_q   <= 1'b0;
            mc_addr_q  <= '0;
            iq_valid_q <= 1'b0;
            iq_inst_q  <= '0;
            iq_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            mc_req_q   <= mc_req_d;
            mc_addr_q  <= mc_addr_d;
            iq_valid_q <= iq_valid_d;
            iq_inst_q  <= iq_inst_d;
            iq_pc_q    <= iq_pc_d;
        end
    end

    assign mc_req_o   = mc_req_q;
    assign mc_addr_o  = mc_addr_q;
    assign iq_valid_o = iq_valid_q;
    assign iq_inst_o  = iq_inst_q;
    assign iq_pc_o    = iq_pc_q;

endmodule
